// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: bus commands, FSM states and tag-owner entries.
package mem_arb_pkg;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_entry_t;

endpackage

// File: rtl/mem_tag_table.sv
// Owner table for outstanding memory tags: one allocate port, one lookup-and-free port.
// Tag 0 means "none" and has no storage.
module mem_tag_table
  import mem_arb_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  owner_t           alloc_owner,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_valid,
  output owner_t           lookup_owner
);

  localparam int DEPTH = 2 ** TAG_W;

  tag_entry_t tab_q [1:DEPTH-1];
  tag_entry_t hit_entry;
  logic       free_en;

  always_comb begin
    hit_entry = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (lookup_tag == TAG_W'(i)) hit_entry = tab_q[i];
    end
  end

  assign lookup_valid = hit_entry.valid;
  assign lookup_owner = hit_entry.owner;
  assign free_en      = (lookup_tag != '0) && hit_entry.valid;

  // A same-cycle allocation of the tag being freed overrides the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) tab_q[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (alloc_en && alloc_tag == TAG_W'(i)) begin
          tab_q[i] <= '{valid: 1'b1, owner: alloc_owner};
        end else if (free_en && lookup_tag == TAG_W'(i)) begin
          tab_q[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Icache/Dcache arbiter for the single memory port, with tag-based return steering.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is Dcache-first with Icache anti-starvation.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int TAG_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       Icache2mem_command_i,
  input  logic [63:0]      Icache2mem_addr_i,
  input  logic [1:0]       Dcache2mem_command_i,
  input  logic [63:0]      Dcache2mem_addr_i,
  input  logic [63:0]      Dcache2mem_data_i,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [63:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_tag,
  output logic [1:0]       proc2mem_command,
  output logic [63:0]      proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic [TAG_W-1:0] mem2Icache_response_o,
  output logic [63:0]      mem2Icache_data_o,
  output logic [TAG_W-1:0] mem2Icache_tag_o,
  output logic [TAG_W-1:0] mem2Dcache_response_o,
  output logic [63:0]      mem2Dcache_data_o,
  output logic [TAG_W-1:0] mem2Dcache_tag_o,
  output logic             mem_arb_err_o
);

  arb_state_t state_q, state_d;
  logic       i_req, d_req;
  logic       pick_i, pick_d;
  logic       grant_i, grant_d;
  logic       rsp_nz, accepted;
  logic       alloc_en;
  logic       lookup_valid;
  owner_t     lookup_owner;
  logic       ret_i, ret_d, ret_bad;
  logic       err_q;

  assign i_req    = (Icache2mem_command_i != BUS_NONE);
  assign d_req    = (Dcache2mem_command_i != BUS_NONE);
  assign rsp_nz   = (mem2proc_response != '0);
  assign accepted = rsp_nz && (grant_i || grant_d);

`ifdef MEM_ARB_RR_EN
  owner_t ptr_q;

  always_comb begin
    pick_i = i_req && (!d_req || ptr_q == OWN_I);
    pick_d = d_req && !pick_i;
  end

  // After an acceptance the other cache becomes the preferred one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= OWN_D;
    end else if (accepted) begin
      ptr_q <= grant_d ? OWN_I : OWN_D;
    end
  end
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q;
  logic             starved;

  assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    pick_i = i_req && (!d_req || starved);
    pick_d = d_req && !pick_i;
  end

  // Counts Icache cycles spent waiting; saturates so a long Dcache burst cannot wrap it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else if (grant_i && rsp_nz) begin
      starve_q <= '0;
    end else if (i_req && !starved) begin
      starve_q <= starve_q + CNT_W'(1);
    end
  end
`endif

  // A locked requester keeps the grant; once it drops its command the
  // normal selection applies in the same cycle.
  always_comb begin
    state_d = IDLE;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      LOCK_I: begin
        grant_i = i_req;
        grant_d = !i_req && pick_d;
      end
      LOCK_D: begin
        grant_d = d_req;
        grant_i = !d_req && pick_i;
      end
      default: begin
        grant_i = pick_i;
        grant_d = pick_d;
      end
    endcase
    if (!rsp_nz) begin
      if (grant_i)      state_d = LOCK_I;
      else if (grant_d) state_d = LOCK_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_d) begin
      proc2mem_command = Dcache2mem_command_i;
      proc2mem_addr    = Dcache2mem_addr_i;
      proc2mem_data    = Dcache2mem_data_i;
    end else if (grant_i) begin
      proc2mem_command = Icache2mem_command_i;
      proc2mem_addr    = Icache2mem_addr_i;
    end
  end

  assign mem2Icache_response_o = grant_i ? mem2proc_response : '0;
  assign mem2Dcache_response_o = grant_d ? mem2proc_response : '0;

  // Only loads produce a data return, so only they claim a tag.
  assign alloc_en = accepted && (proc2mem_command == BUS_LOAD);

  mem_tag_table #(
    .TAG_W(TAG_W)
  ) u_tag_table (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2proc_response),
    .alloc_owner (grant_d ? OWN_D : OWN_I),
    .lookup_tag  (mem2proc_tag),
    .lookup_valid(lookup_valid),
    .lookup_owner(lookup_owner)
  );

  assign ret_i   = (mem2proc_tag != '0) && lookup_valid && (lookup_owner == OWN_I);
  assign ret_d   = (mem2proc_tag != '0) && lookup_valid && (lookup_owner == OWN_D);
  assign ret_bad = (mem2proc_tag != '0) && !lookup_valid;

  assign mem2Icache_tag_o  = ret_i ? mem2proc_tag  : '0;
  assign mem2Icache_data_o = ret_i ? mem2proc_data : '0;
  assign mem2Dcache_tag_o  = ret_d ? mem2proc_tag  : '0;
  assign mem2Dcache_data_o = ret_d ? mem2proc_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_q <= 1'b0;
    else if (ret_bad) err_q <= 1'b1;
  end

  assign mem_arb_err_o = err_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb (default fixed-priority build) with a tag-owner model and return scoreboard.
module tb_mem_arb;

  localparam logic [1:0] B_NONE  = 2'h0;
  localparam logic [1:0] B_LOAD  = 2'h1;
  localparam logic [1:0] B_STORE = 2'h2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  icmd = '0;
  logic [63:0] iaddr = '0;
  logic [1:0]  dcmd = '0;
  logic [63:0] daddr = '0;
  logic [63:0] ddata = '0;
  logic [3:0]  rsp = '0;
  logic [63:0] rdata = '0;
  logic [3:0]  rtag = '0;

  logic [1:0]  p_cmd;
  logic [63:0] p_addr, p_data;
  logic [3:0]  i_rsp, i_tag, d_rsp, d_tag;
  logic [63:0] i_data, d_data;
  logic        err;

  int checks = 0;
  int failures = 0;
  int own_m [16];
  logic err_m = 1'b0;
  logic [135:0] exp_q [$];

  mem_arb dut (
    .clk                  (clk),
    .rst                  (rst),
    .Icache2mem_command_i (icmd),
    .Icache2mem_addr_i    (iaddr),
    .Dcache2mem_command_i (dcmd),
    .Dcache2mem_addr_i    (daddr),
    .Dcache2mem_data_i    (ddata),
    .mem2proc_response    (rsp),
    .mem2proc_data        (rdata),
    .mem2proc_tag         (rtag),
    .proc2mem_command     (p_cmd),
    .proc2mem_addr        (p_addr),
    .proc2mem_data        (p_data),
    .mem2Icache_response_o(i_rsp),
    .mem2Icache_data_o    (i_data),
    .mem2Icache_tag_o     (i_tag),
    .mem2Dcache_response_o(d_rsp),
    .mem2Dcache_data_o    (d_data),
    .mem2Dcache_tag_o     (d_tag),
    .mem_arb_err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [135:0] route_exp(input logic [3:0] t, input logic [63:0] d);
    if (t != 4'h0 && own_m[t] == 1) return {t, d, 4'h0, 64'h0};
    if (t != 4'h0 && own_m[t] == 2) return {4'h0, 64'h0, t, d};
    return '0;
  endfunction

  task automatic check_idle_outputs(input string name);
    chk({name, "_bus"}, {70'h0, p_cmd, p_addr, p_data}, '0);
    chk({name, "_rsp"}, {128'h0, i_rsp, d_rsp}, '0);
    chk({name, "_route"}, {i_tag, i_data, d_tag, d_data}, '0);
    chk({name, "_err"}, {135'h0, err}, '0);
  endtask

  // One clock cycle: drive, check against the expected grant (0 none, 1 Icache, 2 Dcache), update model.
  task automatic step(input string name,
                      input logic [1:0] ic, input logic [63:0] ia,
                      input logic [1:0] dc, input logic [63:0] da, input logic [63:0] dd,
                      input logic [3:0] rs, input logic [3:0] rt, input logic [63:0] rd,
                      input int gnt);
    logic [129:0] exp_bus;
    logic [1:0]   gcmd;
    icmd = ic; iaddr = ia; dcmd = dc; daddr = da; ddata = dd;
    rsp = rs; rtag = rt; rdata = rd;
    exp_bus = (gnt == 2) ? {dc, da, dd} : (gnt == 1) ? {ic, ia, 64'h0} : '0;
    gcmd    = (gnt == 2) ? dc : (gnt == 1) ? ic : B_NONE;
    exp_q.push_back(route_exp(rt, rd));
    #2;
    chk({name, "_bus"}, {6'h0, p_cmd, p_addr, p_data}, {6'h0, exp_bus});
    chk({name, "_rsp"}, {128'h0, i_rsp, d_rsp},
        {128'h0, (gnt == 1) ? rs : 4'h0, (gnt == 2) ? rs : 4'h0});
    chk({name, "_route"}, {i_tag, i_data, d_tag, d_data}, exp_q.pop_front());
    chk({name, "_err"}, {135'h0, err}, {135'h0, err_m});
    if (rt != 4'h0 && own_m[rt] == 0) err_m = 1'b1;
    if (rt != 4'h0) own_m[rt] = 0;
    if (rs != 4'h0 && gnt != 0 && gcmd == B_LOAD) own_m[rs] = gnt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) own_m[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Icache load and its data return
    step("t1_req", B_LOAD, 64'h100, B_NONE, 0, 0, 4'd3, 4'd0, 0, 1);
    step("t1_gap", B_NONE, 0, B_NONE, 0, 0, 4'd0, 4'd0, 0, 0);
    step("t1_ret", B_NONE, 0, B_NONE, 0, 0, 4'd0, 4'd3, 64'hDEAD, 0);

    // Both request; Dcache stays locked until accepted, then Icache
    step("t2_c1", B_LOAD, 64'h140, B_LOAD, 64'h240, 64'h11, 4'd0, 4'd0, 0, 2);
    step("t2_c2", B_LOAD, 64'h140, B_LOAD, 64'h240, 64'h11, 4'd0, 4'd0, 0, 2);
    step("t2_c3", B_LOAD, 64'h140, B_LOAD, 64'h240, 64'h11, 4'd5, 4'd0, 0, 2);
    step("t2_c4", B_LOAD, 64'h140, B_NONE, 0, 0, 4'd7, 4'd0, 0, 1);
    step("t2_ret5", B_NONE, 0, B_NONE, 0, 0, 4'd0, 4'd5, 64'h5555, 0);
    step("t2_ret7", B_NONE, 0, B_NONE, 0, 0, 4'd0, 4'd7, 64'h7777, 0);

    // Icache starved for 8 cycles, then forced ahead of the Dcache
    for (int k = 0; k < 8; k++) begin
      step("t3_dwin", B_LOAD, 64'h180, B_STORE, 64'h280 + 64'(k), 64'(k), 4'd1, 4'd0, 0, 2);
    end
    step("t3_force", B_LOAD, 64'h180, B_STORE, 64'h2FF, 64'h9, 4'd2, 4'd0, 0, 1);
    step("t3_after", B_LOAD, 64'h1C0, B_STORE, 64'h2FF, 64'h9, 4'd1, 4'd0, 0, 2);
    step("t3_ret2", B_NONE, 0, B_NONE, 0, 0, 4'd0, 4'd2, 64'h2222, 0);

    // Store acceptance records nothing; its tag coming back is an error
    step("t4_st", B_NONE, 0, B_STORE, 64'h400, 64'hCAFE, 4'd4, 4'd0, 0, 2);
    step("t4_ret", B_NONE, 0, B_NONE, 0, 0, 4'd0, 4'd4, 64'h4444, 0);
    step("t4_sticky", B_NONE, 0, B_NONE, 0, 0, 4'd0, 4'd0, 0, 0);

    // Tag 6 freed by the Icache and reallocated to the Dcache in one cycle
    step("t5_i6", B_LOAD, 64'h600, B_NONE, 0, 0, 4'd6, 4'd0, 0, 1);
    step("t5_swap", B_NONE, 0, B_LOAD, 64'h660, 0, 4'd6, 4'd6, 64'hAAAA, 2);
    step("t5_d6", B_NONE, 0, B_NONE, 0, 0, 4'd0, 4'd6, 64'hBBBB, 0);

    // Icache lock holds against Dcache; dropping the command releases it the same cycle
    step("t6_lock", B_LOAD, 64'h200, B_NONE, 0, 0, 4'd0, 4'd0, 0, 1);
    step("t6_hold", B_LOAD, 64'h200, B_LOAD, 64'h300, 0, 4'd0, 4'd0, 0, 1);
    step("t6_drop", B_NONE, 0, B_LOAD, 64'h300, 0, 4'd8, 4'd0, 0, 2);
    step("t6_ret8", B_NONE, 0, B_NONE, 0, 0, 4'd0, 4'd8, 64'h8888, 0);

    // Reset with tags 1 and 2 outstanding discards ownership
    step("t7_a1", B_LOAD, 64'h700, B_NONE, 0, 0, 4'd1, 4'd0, 0, 1);
    step("t7_a2", B_NONE, 0, B_LOAD, 64'h780, 0, 4'd2, 4'd0, 0, 2);
    icmd = B_NONE; dcmd = B_NONE; rsp = '0; rtag = '0;
    rst = 1'b1;
    #2;
    check_idle_outputs("t7_rst");
    for (int i = 0; i < 16; i++) own_m[i] = 0;
    err_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("t7_ret1", B_NONE, 0, B_NONE, 0, 0, 4'd0, 4'd1, 64'h1111, 0);
    step("t7_err", B_NONE, 0, B_NONE, 0, 0, 4'd0, 4'd0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
